// File: rtl/spi_mem_arbiter_if.sv
// Requester-side bundle for spi_mem_arbiter: two requesters' request lines
// and the shared grant/done/rdata/busy returns.
interface spi_mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [15:0]         req_wdata;
  logic [1:0]          grant;
  logic [1:0]          done;
  logic [7:0]          rdata;
  logic                busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  grant, done, rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output grant, done, rdata, busy
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory bus between fetch (0) and data (1).
// Ports: clk, rst_n, bus (slave: req_*/grant/done/rdata/busy), spi_cs_n/sclk/mosi/miso.
module spi_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int CLK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_mem_arbiter_if.slave   bus,
  output logic               spi_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  localparam int CW = $clog2(2*CLK_DIV+1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV-1);
  localparam logic [CW-1:0] GAPN = CW'(2*CLK_DIV-1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [39:0]   sr_q, sr_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    done_q, done_d;

  logic              pick;
  logic              we_sel;
  logic [ADDR_W-1:0] a_sel;
  logic [23:0]       a24;
  logic [7:0]        wd_sel;

  // Winner: on contention the requester not served last.
  always_comb begin
    pick = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
    we_sel = bus.req_we[pick];
    a_sel = pick ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                 : bus.req_addr[ADDR_W-1:0];
    a24 = '0;
    a24[ADDR_W-1:0] = a_sel;
    wd_sel = pick ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    grant_d = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          we_d   = we_sel;
          win_d  = pick;
          last_d = pick;
          sr_d   = {we_sel ? 8'h02 : 8'h03, a24,
                    we_sel ? wd_sel : 8'h00};
          grant_d[pick] = 1'b1;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = sr_d[39];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != HALF) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            // Only the trailing data byte carries read data.
            if (bit_q >= 6'd32 && !we_q)
              cap_d = {cap_q[6:0], spi_miso};
          end else if (bit_q == 6'd39) begin
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done_d[win_q] = 1'b1;
            if (!we_q) rdata_d = cap_q;
            state_d = GAP;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 6'd1;
            sr_d   = {sr_q[38:0], sr_q[39]};
            mosi_d = sr_q[38];
          end
        end
      end
      GAP: begin
        if (cnt_q == GAPN) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != IDLE);
  assign spi_cs_n  = cs_n_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: one instance at CLK_DIV=1, one at 3,
// with a mode-0 SPI memory model supplying read bytes.
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n;
  logic cs1, sc1, mo1, cs3, sc3, mo3;
  logic [1:0] miso_v;

  spi_mem_arbiter_if #(.ADDR_W(16)) b1 ();
  spi_mem_arbiter_if #(.ADDR_W(16)) b3 ();

  spi_mem_arbiter #(.ADDR_W(16), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1.slave),
    .spi_cs_n(cs1), .spi_sclk(sc1), .spi_mosi(mo1),
    .spi_miso(miso_v[0])
  );

  spi_mem_arbiter #(.ADDR_W(16), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3.slave),
    .spi_cs_n(cs3), .spi_sclk(sc3), .spi_mosi(mo3),
    .spi_miso(miso_v[1])
  );

  logic [1:0] gr_w [2];
  logic [1:0] dn_w [2];
  assign gr_w[0] = b1.grant;
  assign gr_w[1] = b3.grant;
  assign dn_w[0] = b1.done;
  assign dn_w[1] = b3.done;

  int dv [2] = '{1, 3};

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nlow [2], nrise [2], fcnt [2], run [2], bad [2];
  int lat [2], mingap [2], gc0 [2], gc1 [2], dcnt [2];
  int ncsf [2], viol [2];
  longint gt [2], crise [2];
  logic [39:0] msr [2];
  logic [7:0] mbyte [2];
  logic [1:0] dlast [2];
  logic csp [2], scp [2];
  logic [1:0] glog [$];

  int checks = 0;
  int fails = 0;

  // Bus monitor and SPI memory model, sampled mid-cycle.
  always @(negedge clk) begin
    logic cs, sc, mo;
    logic [1:0] gr, dn;
    for (int k = 0; k < 2; k++) begin
      cs = (k == 0) ? cs1 : cs3;
      sc = (k == 0) ? sc1 : sc3;
      mo = (k == 0) ? mo1 : mo3;
      gr = gr_w[k];
      dn = dn_w[k];
      if (gr != 0 && dn != 0) viol[k]++;
      if (gr != 0 && !$onehot(gr)) viol[k]++;
      if (dn != 0 && !$onehot(dn)) viol[k]++;
      if (gr != 0) begin
        gt[k] = cyc;
        if (gr[0]) gc0[k]++;
        if (gr[1]) gc1[k]++;
        if (k == 0) glog.push_back(gr);
      end
      if (dn != 0) begin
        lat[k] = int'(cyc - gt[k]);
        dlast[k] = dn;
        dcnt[k]++;
      end
      if (!cs && csp[k]) begin
        ncsf[k]++;
        nlow[k] = 1; nrise[k] = 0; fcnt[k] = 0;
        run[k] = 1; bad[k] = 0; msr[k] = '0;
        if (crise[k] >= 0 && int'(cyc - crise[k]) < mingap[k])
          mingap[k] = int'(cyc - crise[k]);
      end else if (!cs) begin
        nlow[k]++;
        if (sc != scp[k]) begin
          if (run[k] != dv[k]) bad[k]++;
          run[k] = 1;
          if (sc) begin
            nrise[k]++;
            msr[k] = {msr[k][38:0], mo};
          end else begin
            fcnt[k]++;
          end
        end else begin
          run[k]++;
        end
      end else if (!csp[k]) begin
        crise[k] = cyc;
        if (scp[k] && run[k] != dv[k]) bad[k]++;
      end
      csp[k] = cs;
      scp[k] = sc;
      miso_v[k] = (!cs && fcnt[k] >= 32 && fcnt[k] < 40)
                  ? mbyte[k][39-fcnt[k]] : 1'b0;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic req(int s, int id, logic we, logic [15:0] a,
                     logic [7:0] wd);
    if (s == 0) begin
      b1.req_we[id] = we;
      b1.req_addr[id*16 +: 16] = a;
      b1.req_wdata[id*8 +: 8] = wd;
      b1.req_valid[id] = 1'b1;
    end else begin
      b3.req_we[id] = we;
      b3.req_addr[id*16 +: 16] = a;
      b3.req_wdata[id*8 +: 8] = wd;
      b3.req_valid[id] = 1'b1;
    end
  endtask

  task automatic drop(int s, int id);
    if (s == 0) b1.req_valid[id] = 1'b0;
    else b3.req_valid[id] = 1'b0;
  endtask

  task automatic wait_g(int s, int id, int base, int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (((id == 0) ? gc0[s] : gc1[s]) > base) return;
    end
    checks++; fails++;
    $display("FAIL grant_timeout inst=%0d id=%0d", s, id);
  endtask

  task automatic wait_d(int s, int base, int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (dcnt[s] > base) return;
    end
    checks++; fails++;
    $display("FAIL done_timeout inst=%0d", s);
  endtask

  task automatic wait_r(int s, int n, int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (nrise[s] >= n) return;
    end
    checks++; fails++;
    $display("FAIL rise_timeout inst=%0d", s);
  endtask

  typedef struct {
    int          sel;
    int          id;
    logic        we;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  mb;
    logic [39:0] mosi;
    logic [7:0]  rd;
  } vec_t;

  vec_t vt [5];

  initial begin
    int g, d, nf, s;
    logic [7:0] rd;

    vt[0] = '{0, 0, 1'b0, 16'h1234, 8'h00, 8'h5A, 40'h0300123400, 8'h5A};
    vt[1] = '{0, 1, 1'b1, 16'h00FF, 8'hC3, 8'hFF, 40'h020000FFC3, 8'h5A};
    vt[2] = '{0, 1, 1'b0, 16'hABCD, 8'h00, 8'h3C, 40'h0300ABCD00, 8'h3C};
    vt[3] = '{0, 0, 1'b1, 16'hFFFF, 8'h81, 8'h00, 40'h0200FFFF81, 8'h3C};
    vt[4] = '{1, 0, 1'b0, 16'h8001, 8'h00, 8'hA5, 40'h0300800100, 8'hA5};

    for (int k = 0; k < 2; k++) begin
      nlow[k] = 0; nrise[k] = 0; fcnt[k] = 0; run[k] = 0; bad[k] = 0;
      lat[k] = 0; mingap[k] = 1 << 30; gc0[k] = 0; gc1[k] = 0;
      dcnt[k] = 0; ncsf[k] = 0; viol[k] = 0; gt[k] = 0; crise[k] = -1;
      msr[k] = '0; mbyte[k] = '0; dlast[k] = '0;
      csp[k] = 1'b1; scp[k] = 1'b0;
    end
    b1.req_valid = '0; b1.req_we = '0; b1.req_addr = '0; b1.req_wdata = '0;
    b3.req_valid = '0; b3.req_we = '0; b3.req_addr = '0; b3.req_wdata = '0;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins1", {cs1, sc1, mo1}, 3'b100);
    chk("reset_bus1", {b1.busy, b1.rdata, b1.grant, b1.done}, '0);
    chk("reset_pins3", {cs3, sc3, mo3}, 3'b100);
    chk("reset_bus3", {b3.busy, b3.rdata, b3.grant, b3.done}, '0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      s = vt[i].sel;
      mbyte[s] = vt[i].mb;
      d = dcnt[s];
      g = (vt[i].id == 0) ? gc0[s] : gc1[s];
      req(s, vt[i].id, vt[i].we, vt[i].a, vt[i].wd);
      wait_g(s, vt[i].id, g, 20);
      drop(s, vt[i].id);
      wait_d(s, d, 100 * dv[s]);
      rd = (s == 0) ? b1.rdata : b3.rdata;
      chk($sformatf("v%0d_done", i), dlast[s], 2'b01 << vt[i].id);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_mosi", i), msr[s], vt[i].mosi);
      chk($sformatf("v%0d_rises", i), nrise[s], 40);
      chk($sformatf("v%0d_cslow", i), nlow[s], 80 * dv[s]);
      chk($sformatf("v%0d_latency", i), lat[s], 80 * dv[s]);
      chk($sformatf("v%0d_sclk_halfper", i), bad[s], 0);
      repeat (4 * dv[s]) @(posedge clk);
      #1;
    end

    // Contention from reset: both held, strict alternation.
    rst1_n = 1'b0;
    mbyte[0] = 8'h66;
    b1.req_we = 2'b00;
    b1.req_addr = {16'h2222, 16'h1111};
    b1.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    glog.delete();
    mingap[0] = 1 << 30;
    d = dcnt[0];
    rst1_n = 1'b1;
    for (int i = 0; i < 400 && glog.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    b1.req_valid = 2'b00;
    wait_d(0, d + 2, 200);
    chk("t3_nGrants", glog.size(), 3);
    if (glog.size() >= 3) begin
      chk("t3_grant0", glog[0], 2'b01);
      chk("t3_grant1", glog[1], 2'b10);
      chk("t3_grant2", glog[2], 2'b01);
    end
    chk("t3_mingap", mingap[0], 3);
    repeat (5) @(posedge clk);
    #1;

    // Reset in the middle of the address phase.
    mbyte[0] = 8'h77;
    g = gc0[0];
    req(0, 0, 1'b0, 16'h1234, 8'h00);
    wait_g(0, 0, g, 20);
    drop(0, 0);
    wait_r(0, 21, 100);
    rst1_n = 1'b0;
    #1;
    chk("t4_rst_pins", {cs1, sc1, mo1}, 3'b100);
    chk("t4_rst_bus", {b1.busy, b1.rdata}, '0);
    d = dcnt[0];
    g = gc0[0];
    req(0, 0, 1'b0, 16'h1234, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst1_n = 1'b1;
    wait_g(0, 0, g, 20);
    drop(0, 0);
    chk("t4_no_done", dcnt[0], d);
    wait_d(0, d, 200);
    chk("t4_done", dlast[0], 2'b01);
    chk("t4_rdata", b1.rdata, 8'h77);
    chk("t4_mosi", msr[0], 40'h0300123400);
    chk("t4_rises", nrise[0], 40);
    repeat (5) @(posedge clk);
    #1;

    // Requester 1 withdraws while requester 0 is being served.
    mbyte[0] = 8'h11;
    g = gc0[0];
    d = dcnt[0];
    req(0, 0, 1'b0, 16'h0042, 8'h00);
    wait_g(0, 0, g, 20);
    drop(0, 0);
    g = gc1[0];
    nf = ncsf[0];
    repeat (3) @(posedge clk);
    #1;
    req(0, 1, 1'b1, 16'h5555, 8'hEE);
    repeat (5) @(posedge clk);
    #1;
    drop(0, 1);
    wait_d(0, d, 200);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_grant1", gc1[0], g);
    chk("t6_no_traffic", ncsf[0], nf);
    chk("t6_done", dlast[0], 2'b01);
    chk("t6_rdata", b1.rdata, 8'h11);

    chk("protocol1", viol[0], 0);
    chk("protocol3", viol[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
